// File: rtl/uart_axil_responder.sv
// AXI4-Lite register front end for a byte UART: TX/RX FIFOs, IER/STATUS/COUNT registers, level IRQ.
// Build with UART_AXIL_LOOPBACK_EN defined to add the CTRL.loopback path (TX head fed straight into RX).
module uart_axil_responder #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        chipset_clk,
  input  logic        chipset_rstn,
  input  logic [12:0] uart_axi_awaddr,
  input  logic        uart_axi_awvalid,
  output logic        uart_axi_awready,
  input  logic [31:0] uart_axi_wdata,
  input  logic        uart_axi_wvalid,
  output logic        uart_axi_wready,
  output logic [1:0]  uart_axi_bresp,
  output logic        uart_axi_bvalid,
  input  logic        uart_axi_bready,
  input  logic [12:0] uart_axi_araddr,
  input  logic        uart_axi_arvalid,
  output logic        uart_axi_arready,
  output logic [31:0] uart_axi_rdata,
  output logic [1:0]  uart_axi_rresp,
  output logic        uart_axi_rvalid,
  input  logic        uart_axi_rready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        uart_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [10:0] A_DATA   = 11'd0;
  localparam logic [10:0] A_IER    = 11'd1;
  localparam logic [10:0] A_STATUS = 11'd2;
  localparam logic [10:0] A_COUNT  = 11'd3;
  localparam logic [10:0] A_CTRL   = 11'd4;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_RESP} rstate_e;

  wstate_e       wstate_q, wstate_d;
  rstate_e       rstate_q, rstate_d;
  logic [1:0]    bresp_q, bresp_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    ier_q, ier_d;
  logic          ovr_q, ovr_d;
  logic          irq_q, irq_d;

  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [AW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          w_fire, r_fire;
  logic          tx_push, tx_pop, rx_pop, rx_push, rx_in_vld;
  logic          ovr_set, ovr_clr;
  logic [7:0]    tx_head, rx_head, rx_in_dat;
  logic [10:0]   w_idx, r_idx;
  logic          lb_en;
  logic [31:0]   ctrl_rdata;
  logic          unused_bits;

  assign w_idx    = uart_axi_awaddr[12:2];
  assign r_idx    = uart_axi_araddr[12:2];
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign tx_head  = tx_mem_q[tx_rd_q];
  assign rx_head  = rx_mem_q[rx_rd_q];

  // Ready outputs stay low while reset is held so nothing is accepted into state about to be cleared.
  assign w_fire           = chipset_rstn && (wstate_q == W_IDLE) && uart_axi_awvalid && uart_axi_wvalid;
  assign uart_axi_awready = w_fire;
  assign uart_axi_wready  = w_fire;
  assign uart_axi_arready = chipset_rstn && (rstate_q == R_IDLE);
  assign r_fire           = uart_axi_arready && uart_axi_arvalid;

  assign uart_axi_bvalid = (wstate_q == W_RESP);
  assign uart_axi_bresp  = bresp_q;
  assign uart_axi_rvalid = (rstate_q == R_RESP);
  assign uart_axi_rdata  = rdata_q;
  assign uart_axi_rresp  = rresp_q;
  assign uart_irq        = irq_q;
  assign unused_bits     = ^{uart_axi_awaddr[1:0], uart_axi_araddr[1:0], uart_axi_wdata[31:8]};

`ifdef UART_AXIL_LOOPBACK_EN
  logic ctrl_lb_q, ctrl_lb_d;
  assign ctrl_lb_d  = (w_fire && (w_idx == A_CTRL)) ? uart_axi_wdata[0] : ctrl_lb_q;
  assign lb_en      = ctrl_lb_q;
  assign ctrl_rdata = {31'b0, ctrl_lb_q};
  always_ff @(posedge chipset_clk) begin
    if (!chipset_rstn) ctrl_lb_q <= 1'b0;
    else               ctrl_lb_q <= ctrl_lb_d;
  end
`else
  assign lb_en      = 1'b0;
  assign ctrl_rdata = 32'b0;
`endif

  // In loopback the TX head drains every cycle into RX and the external stream is muted.
  assign tx_valid  = !lb_en && !tx_empty;
  assign tx_data   = tx_empty ? 8'h00 : tx_head;
  assign tx_pop    = !tx_empty && (lb_en || tx_ready);
  assign rx_in_vld = lb_en ? !tx_empty : rx_valid;
  assign rx_in_dat = lb_en ? tx_head : rx_data;
  assign rx_push   = rx_in_vld && (!rx_full || rx_pop);
  assign ovr_set   = rx_in_vld && rx_full && !rx_pop;

  always_comb begin
    wstate_d = wstate_q;
    bresp_d  = bresp_q;
    ier_d    = ier_q;
    tx_push  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (w_fire) begin
          wstate_d = W_RESP;
          bresp_d  = RESP_OKAY;
          case (w_idx)
            A_DATA: begin
              if (tx_full) bresp_d = RESP_SLVERR;
              else         tx_push = 1'b1;
            end
            A_IER:                     ier_d = uart_axi_wdata[1:0];
            A_STATUS, A_COUNT, A_CTRL: ;
            default:                   bresp_d = RESP_DECERR;
          endcase
        end
      end
      W_RESP:  if (uart_axi_bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rx_pop   = 1'b0;
    ovr_clr  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (r_fire) begin
          rstate_d = R_RESP;
          rresp_d  = RESP_OKAY;
          rdata_d  = 32'b0;
          case (r_idx)
            A_DATA: begin
              if (!rx_empty) begin
                rdata_d = {24'b0, rx_head};
                rx_pop  = 1'b1;
              end
            end
            A_IER:    rdata_d = {30'b0, ier_q};
            A_STATUS: begin
              rdata_d = {27'b0, ovr_q, tx_full, tx_empty, rx_full, !rx_empty};
              ovr_clr = 1'b1;
            end
            A_COUNT:  rdata_d = {16'b0, 8'(rx_cnt_q), 8'(tx_cnt_q)};
            A_CTRL:   rdata_d = ctrl_rdata;
            default:  rresp_d = RESP_DECERR;
          endcase
        end
      end
      R_RESP:  if (uart_axi_rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // A fresh overrun in the same cycle as a STATUS read survives, since the read reported the older value.
  always_comb begin
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    tx_wr_d  = tx_wr_q + AW'(tx_push);
    tx_rd_d  = tx_rd_q + AW'(tx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    rx_wr_d  = rx_wr_q + AW'(rx_push);
    rx_rd_d  = rx_rd_q + AW'(rx_pop);
    ovr_d    = ovr_set || (ovr_q && !ovr_clr);
    irq_d    = (ier_q[0] && !rx_empty) || (ier_q[1] && tx_empty);
  end

  always_ff @(posedge chipset_clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= uart_axi_wdata[7:0];
    if (rx_push) rx_mem_q[rx_wr_q] <= rx_in_dat;
  end

  always_ff @(posedge chipset_clk) begin
    if (!chipset_rstn) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      bresp_q  <= 2'b00;
      rresp_q  <= 2'b00;
      rdata_q  <= 32'b0;
      ier_q    <= 2'b00;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
      tx_rd_q  <= '0;
      tx_wr_q  <= '0;
      tx_cnt_q <= '0;
      rx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      ier_q    <= ier_d;
      ovr_q    <= ovr_d;
      irq_q    <= irq_d;
      tx_rd_q  <= tx_rd_d;
      tx_wr_q  <= tx_wr_d;
      tx_cnt_q <= tx_cnt_d;
      rx_rd_q  <= rx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_axil_responder.sv
// Scoreboarded bench for uart_axil_responder: a queue-level UART model predicts every response,
// a negedge monitor compares B/R/TX handshakes against the expectation queues.
module tb_uart_axil_responder;
  localparam int D = 16;
`ifdef UART_AXIL_LOOPBACK_EN
  localparam bit LB_BUILT = 1'b1;
`else
  localparam bit LB_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [12:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, irq;

  always #5 clk = ~clk;

  uart_axil_responder #(.FIFO_DEPTH(D)) dut (
    .chipset_clk(clk), .chipset_rstn(rstn),
    .uart_axi_awaddr(awaddr), .uart_axi_awvalid(awvalid), .uart_axi_awready(awready),
    .uart_axi_wdata(wdata), .uart_axi_wvalid(wvalid), .uart_axi_wready(wready),
    .uart_axi_bresp(bresp), .uart_axi_bvalid(bvalid), .uart_axi_bready(bready),
    .uart_axi_araddr(araddr), .uart_axi_arvalid(arvalid), .uart_axi_arready(arready),
    .uart_axi_rdata(rdata), .uart_axi_rresp(rresp), .uart_axi_rvalid(rvalid), .uart_axi_rready(rready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .uart_irq(irq)
  );

  // Reference model state
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  logic [1:0]  m_ier;
  bit          m_ovr, m_lb;
  bit          w_busy, r_busy, irq_exp;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [7:0]  exp_tx[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: handshake seen with no expected entry", name);
  endtask

  always @(negedge clk) begin : mon
    logic [33:0] e;
    if (bvalid === 1'b1 && bready === 1'b1) begin
      if (exp_b.size() == 0) fail_unexpected("bresp");
      else check("bresp", bresp, exp_b.pop_front());
    end
    if (rvalid === 1'b1 && rready === 1'b1) begin
      if (exp_r.size() == 0) fail_unexpected("rdata");
      else begin
        e = exp_r.pop_front();
        check("rresp", rresp, e[33:32]);
        check("rdata", rdata, e[31:0]);
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_tx.size() == 0) fail_unexpected("tx_data");
      else check("tx_data", tx_data, exp_tx.pop_front());
    end
  end

  // One clock of stimulus; the model advances by the same cycle's rules.
  task automatic cyc(input bit w_en, input logic [12:0] wa, input logic [31:0] wd,
                     input bit r_en, input logic [12:0] ra,
                     input bit rxv, input logic [7:0] rxd, input bit txr,
                     input bit brdy, input bit rrdy);
    bit do_w, do_r, rx_pop, tx_pop, tx_push, in_v, ovr_set, ovr_clr;
    bit exp_bv, exp_rv, exp_arr, exp_txv, irq_chk, irq_next, lb_next;
    int txn, rxn;
    logic [7:0]  in_d;
    logic [31:0] rd;
    logic [1:0]  rr, br, ier_next;
    @(posedge clk);
    #1;
    do_w = w_en && !w_busy;
    do_r = r_en && !r_busy;
    awaddr = wa; wdata = wd; awvalid = do_w; wvalid = do_w;
    araddr = ra; arvalid = do_r;
    rx_valid = rxv; rx_data = rxd; tx_ready = txr;
    bready = brdy; rready = rrdy;

    txn = m_tx.size();
    rxn = m_rx.size();
    exp_bv = w_busy; exp_rv = r_busy; exp_arr = !r_busy;
    exp_txv = !m_lb && txn > 0;
    irq_chk = irq_exp;
    irq_next = (m_ier[0] && rxn > 0) || (m_ier[1] && txn == 0);
    rx_pop = 0; ovr_clr = 0; ovr_set = 0; tx_push = 0;
    ier_next = m_ier; lb_next = m_lb;

    if (do_r) begin
      rr = 2'b00; rd = 32'h0;
      case (ra[12:2])
        0: if (rxn > 0) begin rd = {24'h0, m_rx[0]}; rx_pop = 1; end
        1: rd = {30'h0, m_ier};
        2: begin
          rd = {27'h0, m_ovr, (txn == D), (txn == 0), (rxn == D), (rxn > 0)};
          ovr_clr = 1;
        end
        3: rd = {16'h0, 8'(rxn), 8'(txn)};
        4: rd = LB_BUILT ? {31'h0, m_lb} : 32'h0;
        default: rr = 2'b11;
      endcase
      exp_r.push_back({rr, rd});
    end
    if (do_w) begin
      br = 2'b00;
      case (wa[12:2])
        0: if (txn == D) br = 2'b10; else tx_push = 1;
        1: ier_next = wd[1:0];
        2, 3: ;
        4: if (LB_BUILT) lb_next = wd[0];
        default: br = 2'b11;
      endcase
      exp_b.push_back(br);
    end

    tx_pop = txn > 0 && (m_lb || txr);
    in_v = rxv;
    in_d = rxd;
    if (m_lb) begin
      in_v = tx_pop;
      if (tx_pop) in_d = m_tx[0];
    end
    if (tx_pop) begin
      if (!m_lb) exp_tx.push_back(m_tx[0]);
      void'(m_tx.pop_front());
    end
    if (tx_push) m_tx.push_back(wd[7:0]);
    if (rx_pop) void'(m_rx.pop_front());
    if (in_v) begin
      if (rxn < D || rx_pop) m_rx.push_back(in_d);
      else ovr_set = 1;
    end
    if (ovr_clr) m_ovr = 0;
    if (ovr_set) m_ovr = 1;
    m_ier = ier_next;
    m_lb = lb_next;
    if (w_busy && brdy) w_busy = 0;
    if (do_w) w_busy = 1;
    if (r_busy && rrdy) r_busy = 0;
    if (do_r) r_busy = 1;

    @(negedge clk);
    check("awready", awready, do_w);
    check("wready", wready, do_w);
    check("arready", arready, exp_arr);
    check("bvalid", bvalid, exp_bv);
    check("rvalid", rvalid, exp_rv);
    check("tx_valid", tx_valid, exp_txv);
    check("uart_irq", irq, irq_chk);
    irq_exp = irq_next;
  endtask

  task automatic idle(input int n, input bit txr);
    for (int i = 0; i < n; i++) cyc(0, 13'h0, 32'h0, 0, 13'h0, 0, 8'h0, txr, 1, 1);
  endtask

  task automatic wr(input logic [12:0] a, input logic [31:0] d, input bit txr);
    cyc(1, a, d, 0, 13'h0, 0, 8'h0, txr, 1, 1);
    for (int i = 0; i < 4 && w_busy; i++) idle(1, txr);
  endtask

  task automatic rd(input logic [12:0] a, input bit txr);
    cyc(0, 13'h0, 32'h0, 1, a, 0, 8'h0, txr, 1, 1);
    for (int i = 0; i < 4 && r_busy; i++) idle(1, txr);
  endtask

  task automatic model_reset();
    m_tx.delete(); m_rx.delete(); exp_b.delete(); exp_r.delete(); exp_tx.delete();
    m_ier = 2'b00; m_ovr = 0; m_lb = 0; w_busy = 0; r_busy = 0; irq_exp = 0;
  endtask

  function automatic logic [12:0] rand_addr();
    logic [12:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2: a = 13'h000;
      3:       a = 13'h004;
      4:       a = 13'h008;
      5:       a = 13'h00C;
      6:       a = 13'h010;
      7:       a = 13'h014;
      8:       a = 13'h1FC;
      default: a = {11'($urandom_range(5, 2047)), 2'b00};
    endcase
    a[1:0] = 2'($urandom);
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    model_reset();
    rstn = 0;
    awaddr = 0; wdata = 0; araddr = 0; rx_data = 0;
    awvalid = 1; wvalid = 1; arvalid = 1;
    bready = 0; rready = 0; tx_ready = 0; rx_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst awready", awready, 0);
    check("rst wready", wready, 0);
    check("rst arready", arready, 0);
    check("rst bvalid", bvalid, 0);
    check("rst rvalid", rvalid, 0);
    check("rst bresp", bresp, 0);
    check("rst rresp", rresp, 0);
    check("rst rdata", rdata, 0);
    check("rst tx_valid", tx_valid, 0);
    check("rst tx_data", tx_data, 0);
    check("rst uart_irq", irq, 0);
    @(posedge clk);
    #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    rstn = 1;

    rd(13'h008, 1);                           // STATUS after reset: tx_empty only
    wr(13'h000, 32'h41, 1);
    wr(13'h000, 32'h42, 1);
    wr(13'h004, 32'h2, 1);                    // TX-empty interrupt enable
    idle(2, 1);

    for (int i = 0; i < 17; i++) cyc(0, 13'h0, 32'h0, 0, 13'h0, 1, 8'(8'hA0 + i), 1, 1, 1);
    rd(13'h008, 1);                           // overrun + rx full
    rd(13'h000, 1);
    rd(13'h00C, 1);
    rd(13'h008, 1);
    cyc(0, 13'h0, 32'h0, 0, 13'h0, 1, 8'h5C, 1, 1, 1);  // refill to full
    cyc(0, 13'h0, 32'h0, 1, 13'h000, 1, 8'h5D, 1, 1, 1); // push+pop while full
    idle(1, 1);
    rd(13'h008, 1);
    rd(13'h00C, 1);

    for (int i = 0; i < 17; i++) wr(13'h000, 32'h100 + i, 0);
    rd(13'h00C, 0);
    idle(20, 1);

    rd(13'h1FC, 1);
    wr(13'h100, 32'hDEAD_BEEF, 1);
    wr(13'h004, 32'h1, 1);
    rd(13'h004, 1);
    rd(13'h010, 1);

    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 2) == 0, rand_addr(), $urandom,
          $urandom_range(0, 2) == 0, rand_addr(),
          $urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 10 && (w_busy || r_busy); i++) idle(1, 1);
    wr(13'h010, 32'h0, 1);
    idle(20, 1);

    // Reset while a read response is still pending discards it.
    cyc(0, 13'h0, 32'h0, 1, 13'h008, 0, 8'h0, 1, 1, 0);
    @(posedge clk);
    #1;
    rstn = 0; arvalid = 0; awvalid = 0; wvalid = 0; rready = 0;
    @(posedge clk);
    @(negedge clk);
    check("mid-reset rvalid", rvalid, 0);
    check("mid-reset tx_valid", tx_valid, 0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1;
    rd(13'h008, 1);

`ifdef UART_AXIL_LOOPBACK_EN
    wr(13'h010, 32'h1, 1);
    wr(13'h000, 32'h5A, 1);
    idle(3, 1);
    rd(13'h000, 1);
    rd(13'h010, 1);
    wr(13'h010, 32'h0, 1);
`endif
    idle(4, 1);

    check("pending B drained", exp_b.size(), 0);
    check("pending R drained", exp_r.size(), 0);
    check("pending TX drained", exp_tx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
